// File: rtl/debug_halt_ctrl.sv
// debug_halt_ctrl: debug halt/resume sequencer that parks the core, holds the debug PC and redirects fetch on resume.
//   Optional single-step support is compiled in with `define DBG_STEP_EN.
//   Ports:
//     clk, rst                  clock, asynchronous active-high reset
//     halt_req                  level halt request from the debug module
//     resume_req, step_req      one-cycle resume request; step_req turns it into a single step
//     pipe_empty, instr_retire  pipeline drained / one instruction retired this cycle
//     pc_current                PC of the next instruction to execute
//     dpc_wr_en, dpc_wr_data    debugger write port for dpc (honoured only while halted)
//     pc_sel, dpc               select and data1 of the downstream PC mux
//     stall, halted, resume_ack fetch/issue freeze, halt status, one-cycle resume acknowledge
//     halt_cycles               saturating count of cycles spent halted
module debug_halt_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic             step_req,
    input  logic             pipe_empty,
    input  logic             instr_retire,
    input  logic [31:0]      pc_current,
    input  logic             dpc_wr_en,
    input  logic [31:0]      dpc_wr_data,
    output logic             pc_sel,
    output logic [31:0]      dpc,
    output logic             stall,
    output logic             halted,
    output logic             resume_ack,
    output logic [CNT_W-1:0] halt_cycles
);

`ifdef DBG_STEP_EN
    typedef enum logic [2:0] {RUNNING, HALT_PEND, HALTED, RESUME, STEP} state_t;
`else
    typedef enum logic [1:0] {RUNNING, HALT_PEND, HALTED, RESUME} state_t;
`endif

    state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUNNING;
        else     state <= state_nxt;
    end

`ifdef DBG_STEP_EN
    // Remembers whether the accepted resume was a step, so RESUME knows where to go.
    logic step_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              step_q <= 1'b0;
        else if (state == HALTED && resume_req) step_q <= step_req;
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{step_req, instr_retire};
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            RUNNING:   if (halt_req)   state_nxt = HALT_PEND;
            HALT_PEND: if (pipe_empty) state_nxt = HALTED;
            HALTED:    if (resume_req) state_nxt = RESUME;
`ifdef DBG_STEP_EN
            RESUME:    state_nxt = step_q ? STEP : RUNNING;
            STEP:      if (instr_retire) state_nxt = HALT_PEND;
`else
            RESUME:    state_nxt = RUNNING;
`endif
            default:   state_nxt = RUNNING;
        endcase
    end

    // Status outputs decode the state register directly, so they are glitch-free
    // and the fetch redirect is exactly as wide as RESUME.
    assign pc_sel     = (state == RESUME);
    assign resume_ack = (state == RESUME);
    assign stall      = (state == HALT_PEND) || (state == HALTED);
    assign halted     = (state == HALTED);

    // A write accepted in the same cycle as resume_req lands before RESUME, so the
    // redirect uses the freshly written PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     dpc <= RESET_PC;
        else if (state == HALT_PEND && pipe_empty)   dpc <= pc_current;
        else if (state == HALTED && dpc_wr_en)       dpc <= dpc_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                halt_cycles <= '0;
        else if (state_nxt == HALT_PEND && state != HALT_PEND)  halt_cycles <= '0;
        else if (state == HALTED && halt_cycles != '1)          halt_cycles <= halt_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// tb_debug_halt_ctrl: scoreboard bench for debug_halt_ctrl (default and DBG_STEP_EN builds).
module tb_debug_halt_ctrl;

    localparam int RUN = 0, PEND = 1, HALT = 2, RES = 3, STP = 4;

    typedef struct packed {
        logic        ps;
        logic        st;
        logic        ha;
        logic        ak;
        logic [31:0] dpc;
        logic [15:0] hc;
        logic [3:0]  hc4;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        halt_req = 1'b0, resume_req = 1'b0, step_req = 1'b0;
    logic        pipe_empty = 1'b0, instr_retire = 1'b0, dpc_wr_en = 1'b0;
    logic [31:0] pc_current = '0, dpc_wr_data = '0;
    logic        pc_sel, stall, halted, resume_ack;
    logic [31:0] dpc;
    logic [15:0] hc;
    logic        pc_sel4, stall4, halted4, resume_ack4;
    logic [31:0] dpc4;
    logic [3:0]  hc4;

    int   n_run = 0, n_fail = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    debug_halt_ctrl dut (
        .clk(clk), .rst(rst), .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
        .pipe_empty(pipe_empty), .instr_retire(instr_retire), .pc_current(pc_current),
        .dpc_wr_en(dpc_wr_en), .dpc_wr_data(dpc_wr_data), .pc_sel(pc_sel), .dpc(dpc),
        .stall(stall), .halted(halted), .resume_ack(resume_ack), .halt_cycles(hc)
    );

    debug_halt_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
        .pipe_empty(pipe_empty), .instr_retire(instr_retire), .pc_current(pc_current),
        .dpc_wr_en(dpc_wr_en), .dpc_wr_data(dpc_wr_data), .pc_sel(pc_sel4), .dpc(dpc4),
        .stall(stall4), .halted(halted4), .resume_ack(resume_ack4), .halt_cycles(hc4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int s, input logic [31:0] d, input int h);
        exp_t x;
        x.ps  = (s == RES);
        x.ak  = (s == RES);
        x.st  = (s == PEND) || (s == HALT);
        x.ha  = (s == HALT);
        x.dpc = d;
        x.hc  = 16'(h);
        x.hc4 = (h > 15) ? 4'hF : 4'(h);
        q.push_back(x);
    endtask

    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        x = q.pop_front();
        chk("pc_sel", {31'b0, pc_sel}, {31'b0, x.ps});
        chk("resume_ack", {31'b0, resume_ack}, {31'b0, x.ak});
        chk("stall", {31'b0, stall}, {31'b0, x.st});
        chk("halted", {31'b0, halted}, {31'b0, x.ha});
        chk("dpc", dpc, x.dpc);
        chk("halt_cycles", {16'b0, hc}, {16'b0, x.hc});
        chk("halt_cycles_w4", {28'b0, hc4}, {28'b0, x.hc4});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pc_sel"}, {31'b0, pc_sel}, 32'd0);
        chk({tag, "_ack"}, {31'b0, resume_ack}, 32'd0);
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        chk({tag, "_halted"}, {31'b0, halted}, 32'd0);
        chk({tag, "_dpc"}, dpc, 32'd0);
        chk({tag, "_hc"}, {16'b0, hc}, 32'd0);
    endtask

    initial begin
        push(RUN, 0, 0); tick();
        push(RUN, 0, 0); tick();
        rst = 1'b0;
        // halt with a pipeline that drains after three cycles; halt_req dropped mid-pend
        halt_req = 1'b1; pc_current = 32'h0000_0100;
        push(PEND, 0, 0); tick();
        halt_req = 1'b0;
        push(PEND, 0, 0); tick();
        push(PEND, 0, 0); tick();
        push(PEND, 0, 0); tick();
        pipe_empty = 1'b1; pc_current = 32'h0000_0104;
        push(HALT, 32'h104, 0); tick();
        pipe_empty = 1'b0; pc_current = 32'h0000_0900;
        for (int i = 1; i < 10; i++) begin
            push(HALT, 32'h104, i); tick();
        end
        // dpc write together with resume: RESUME shows the new value
        dpc_wr_en = 1'b1; dpc_wr_data = 32'h0000_0200; resume_req = 1'b1;
        push(RES, 32'h200, 10); tick();
        dpc_wr_en = 1'b0; resume_req = 1'b0;
        push(RUN, 32'h200, 10); tick();
        push(RUN, 32'h200, 10); tick();
        // writes and resume requests while running are ignored
        dpc_wr_en = 1'b1; dpc_wr_data = 32'hDEAD_BEEF; resume_req = 1'b1;
        push(RUN, 32'h200, 10); tick();
        dpc_wr_en = 1'b0; resume_req = 1'b0;
        push(RUN, 32'h200, 10); tick();
        // long halt with halt_req held: saturation and immediate re-halt
        halt_req = 1'b1; pipe_empty = 1'b1; pc_current = 32'h0000_0300;
        push(PEND, 32'h200, 0); tick();
        push(HALT, 32'h300, 0); tick();
        pc_current = 32'h0000_0999;
        for (int i = 1; i < 20; i++) begin
            push(HALT, 32'h300, i); tick();
        end
        resume_req = 1'b1;
        push(RES, 32'h300, 20); tick();
        resume_req = 1'b0;
        push(RUN, 32'h300, 20); tick();
        push(PEND, 32'h300, 0); tick();
        pc_current = 32'h0000_0400;
        push(HALT, 32'h400, 0); tick();
        halt_req = 1'b0;
        push(HALT, 32'h400, 1); tick();
        // asynchronous reset mid-HALTED
        #2 rst = 1'b1;
        #1 chk_idle("async_rst_halted");
        push(RUN, 0, 0); tick();
        rst = 1'b0;
        push(RUN, 0, 0); tick();
        // asynchronous reset mid-RESUME leaves no redirect behind
        halt_req = 1'b1; pc_current = 32'h0000_0600;
        push(PEND, 0, 0); tick();
        halt_req = 1'b0;
        push(HALT, 32'h600, 0); tick();
        resume_req = 1'b1;
        push(RES, 32'h600, 1); tick();
        resume_req = 1'b0;
        #2 rst = 1'b1;
        #1 chk_idle("async_rst_resume");
        push(RUN, 0, 0); tick();
        rst = 1'b0;
        push(RUN, 0, 0); tick();
        // single-step request
        halt_req = 1'b1; pc_current = 32'h0000_0500;
        push(PEND, 0, 0); tick();
        halt_req = 1'b0;
        push(HALT, 32'h500, 0); tick();
        pipe_empty = 1'b0; resume_req = 1'b1; step_req = 1'b1;
        push(RES, 32'h500, 1); tick();
        resume_req = 1'b0; step_req = 1'b0;
`ifdef DBG_STEP_EN
        push(STP, 32'h500, 1); tick();
        push(STP, 32'h500, 1); tick();
        instr_retire = 1'b1; pipe_empty = 1'b1; pc_current = 32'h0000_0504;
        push(PEND, 32'h500, 0); tick();
        instr_retire = 1'b0;
        push(HALT, 32'h504, 0); tick();
        push(HALT, 32'h504, 1); tick();
`else
        push(RUN, 32'h500, 1); tick();
        push(RUN, 32'h500, 1); tick();
        instr_retire = 1'b1; pipe_empty = 1'b1; pc_current = 32'h0000_0504;
        push(RUN, 32'h500, 1); tick();
        instr_retire = 1'b0;
        push(RUN, 32'h500, 1); tick();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
